// File: rtl/uio_bus_arbiter_if.sv
// Bundle of requester handshake signals and uio pad signals shared by the
// arbiter (master side) and the requesters/pads (slave side).
interface uio_bus_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 8
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    req_wr;
  logic [2*N_REQ-1:0]  req_len;
  logic [DW*N_REQ-1:0] req_wdata;
  logic [N_REQ-1:0]    gnt;
  logic                beat;
  logic                last;
  logic [DW-1:0]       rdata;
  logic                rvalid;
  logic [DW-1:0]       uio_in;
  logic [DW-1:0]       uio_out;
  logic [DW-1:0]       uio_oe;

  modport master (
    input  req, req_wr, req_len, req_wdata, uio_in,
    output gnt, beat, last, rdata, rvalid, uio_out, uio_oe
  );

  modport slave (
    output req, req_wr, req_len, req_wdata, uio_in,
    input  gnt, beat, last, rdata, rvalid, uio_out, uio_oe
  );
endinterface

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the tile's uio pin bus: grants committed 1-4 beat
// read/write bursts and inserts a turnaround cycle on each direction change.
module uio_bus_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ena,
  uio_bus_if.master   bus
);
  localparam int PW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TURN = 2'd1,
    S_XFER = 2'd2
  } state_t;

  state_t           r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [PW-1:0]    r_ptr;
  logic             r_dir;
  logic             r_wr;
  logic [1:0]       r_cnt;
  logic             r_beat;
  logic             r_last;
  logic [DW-1:0]    r_rdata;
  logic             r_rvalid;

  logic             w_any;
  logic [PW-1:0]    w_win;
  logic [PW-1:0]    w_idx;
  logic [PW-1:0]    w_ptr_nxt;
  logic [1:0]       w_len;
  logic [DW-1:0]    w_wdata;
  logic [DW-1:0]    w_out;
  logic [DW-1:0]    w_oe;
  int               w_j;

  // Round-robin search: first requester at or after r_ptr, wrapping mod N_REQ.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_j   = 0;
    w_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_j = int'(r_ptr) + i;
      if (w_j >= N_REQ) begin
        w_j = w_j - N_REQ;
      end else begin
        w_j = w_j;
      end
      w_idx = PW'(w_j);
      if (!w_any && bus.req[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end else begin
        w_win = w_win;
      end
    end
  end

  // Pointer wrap and the winner's burst length.
  always_comb begin
    if (w_win == PW'(N_REQ - 1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = w_win + PW'(1);
    end
    w_len = bus.req_len[{w_win, 1'b0} +: 2];
  end

  // Write-data mux selected by the registered one-hot grant.
  always_comb begin
    w_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_gnt[i]) begin
        w_wdata = w_wdata | bus.req_wdata[i*DW +: DW];
      end else begin
        w_wdata = w_wdata;
      end
    end
  end

  // Pads are only driven during write beats; everything else leaves them released.
  always_comb begin
    if ((r_state == S_XFER) && r_wr) begin
      w_oe  = {DW{1'b1}};
      w_out = w_wdata;
    end else begin
      w_oe  = {DW{1'b0}};
      w_out = {DW{1'b0}};
    end
  end

  // Arbitration / turnaround / transfer sequencer with registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_ptr    <= '0;
      r_dir    <= 1'b0;
      r_wr     <= 1'b0;
      r_cnt    <= 2'd0;
      r_beat   <= 1'b0;
      r_last   <= 1'b0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_ena && w_any) begin
            r_gnt <= N_REQ'(1) << w_win;
            r_wr  <= bus.req_wr[w_win];
            r_cnt <= w_len;
            r_ptr <= w_ptr_nxt;
            if (bus.req_wr[w_win] != r_dir) begin
              r_state <= S_TURN;
              r_beat  <= 1'b0;
              r_last  <= 1'b0;
            end else begin
              r_state <= S_XFER;
              r_beat  <= 1'b1;
              r_last  <= (w_len == 2'd0);
            end
          end else begin
            r_gnt  <= '0;
            r_beat <= 1'b0;
            r_last <= 1'b0;
          end
        end
        S_TURN: begin
          r_dir   <= r_wr;
          r_state <= S_XFER;
          r_beat  <= 1'b1;
          r_last  <= (r_cnt == 2'd0);
        end
        S_XFER: begin
          if (!r_wr) begin
            r_rdata  <= bus.uio_in;
            r_rvalid <= 1'b1;
          end
          // The burst length is committed at grant; only the counter ends it.
          if (r_cnt == 2'd0) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_beat  <= 1'b0;
            r_last  <= 1'b0;
            r_dir   <= r_wr;
          end else begin
            r_cnt  <= r_cnt - 2'd1;
            r_last <= (r_cnt == 2'd1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
          r_beat  <= 1'b0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.beat    = r_beat;
  assign bus.last    = r_last;
  assign bus.rdata   = r_rdata;
  assign bus.rvalid  = r_rvalid;
  assign bus.uio_out = w_out;
  assign bus.uio_oe  = w_oe;
endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter: inputs change and outputs are checked
// on the falling clock edge.
module tb_uio_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  uio_bus_if #(.N_REQ(4), .DW(8)) bus ();

  uio_bus_arbiter #(.N_REQ(4), .DW(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_ena (ena),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [3:0] g, input logic b,
                         input logic l, input logic [7:0] oe, input logic [7:0] o);
    chk({tag, ".gnt"},  32'(bus.gnt),     32'(g));
    chk({tag, ".beat"}, 32'(bus.beat),    32'(b));
    chk({tag, ".last"}, 32'(bus.last),    32'(l));
    chk({tag, ".oe"},   32'(bus.uio_oe),  32'(oe));
    chk({tag, ".out"},  32'(bus.uio_out), 32'(o));
  endtask

  logic [3:0] exp_order [5];
  logic [7:0] rd_vals   [3];

  initial begin
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rd_vals   = '{8'h11, 8'h22, 8'h33};
    bus.req       = 4'b0000;
    bus.req_wr    = 4'b0000;
    bus.req_len   = 8'h00;
    bus.req_wdata = 32'h0;
    bus.uio_in    = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    chk_bus("rst", 4'b0000, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("rst.rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst.rdata",  32'(bus.rdata),  32'h00);
    rst = 1'b0;
    ena = 1'b1;

    // 4-beat write from req0, reset asynchronously during beat 2
    bus.req       = 4'b0001;
    bus.req_wr    = 4'b0001;
    bus.req_len   = 8'b0000_0011;
    bus.req_wdata = 32'h0000_005A;
    @(negedge clk); chk_bus("w4_turn", 4'b0001, 1'b0, 1'b0, 8'h00, 8'h00);
    bus.req = 4'b0000;
    @(negedge clk); chk_bus("w4_b1", 4'b0001, 1'b1, 1'b0, 8'hFF, 8'h5A);
    @(negedge clk); chk_bus("w4_b2", 4'b0001, 1'b1, 1'b0, 8'hFF, 8'h5A);
    #1 rst = 1'b1;
    #1 chk_bus("w4_arst", 4'b0000, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    rst         = 1'b0;
    bus.req     = 4'b0011;
    bus.req_wr  = 4'b0000;
    bus.req_len = 8'h00;
    bus.uio_in  = 8'h99;
    @(negedge clk); chk_bus("post_rst_win0", 4'b0001, 1'b1, 1'b1, 8'h00, 8'h00);
    bus.req = 4'b0000;
    @(negedge clk);
    chk("post_rst_idle.gnt", 32'(bus.gnt),    32'd0);
    chk("post_rst.rvalid",   32'(bus.rvalid), 32'd1);
    chk("post_rst.rdata",    32'(bus.rdata),  32'h99);

    // Round-robin fairness from a fresh pointer
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_bus($sformatf("rr%0d", k), exp_order[k], 1'b1, 1'b1, 8'h00, 8'h00);
      if (k == 4) bus.req = 4'b0000;
      @(negedge clk);
      chk($sformatf("rr%0d_idle.gnt", k),    32'(bus.gnt),    32'd0);
      chk($sformatf("rr%0d_idle.rvalid", k), 32'(bus.rvalid), 32'd1);
    end

    // Write after read needs a turnaround; then read after write
    bus.req       = 4'b0001;
    bus.req_wr    = 4'b0001;
    bus.req_len   = 8'b0000_0001;
    bus.req_wdata = 32'h0000_00A5;
    @(negedge clk); chk_bus("ta_turn", 4'b0001, 1'b0, 1'b0, 8'h00, 8'h00);
    bus.req     = 4'b0010;
    bus.req_wr  = 4'b0000;
    bus.req_len = 8'h00;
    bus.uio_in  = 8'h3C;
    @(negedge clk); chk_bus("ta_w1",    4'b0001, 1'b1, 1'b0, 8'hFF, 8'hA5);
    @(negedge clk); chk_bus("ta_w2",    4'b0001, 1'b1, 1'b1, 8'hFF, 8'hA5);
    @(negedge clk); chk_bus("ta_idle",  4'b0000, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk); chk_bus("ta_turn2", 4'b0010, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk); chk_bus("ta_rd",    4'b0010, 1'b1, 1'b1, 8'h00, 8'h00);
    bus.req = 4'b0000;
    @(negedge clk);
    chk("ta_end.gnt",    32'(bus.gnt),    32'd0);
    chk("ta_end.rvalid", 32'(bus.rvalid), 32'd1);
    chk("ta_end.rdata",  32'(bus.rdata),  32'h3C);

    // Committed 4-beat write from req2: req and ena dropped after beat 1
    bus.req       = 4'b0100;
    bus.req_wr    = 4'b0100;
    bus.req_len   = 8'b0011_0000;
    bus.req_wdata = 32'h0077_0000;
    @(negedge clk); chk_bus("cb_turn", 4'b0100, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk); chk_bus("cb_b1",   4'b0100, 1'b1, 1'b0, 8'hFF, 8'h77);
    bus.req = 4'b0001;
    ena     = 1'b0;
    for (int b = 2; b <= 4; b++) begin
      @(negedge clk);
      chk_bus($sformatf("cb_b%0d", b), 4'b0100, 1'b1, (b == 4), 8'hFF, 8'h77);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_bus($sformatf("cb_hold%0d", c), 4'b0000, 1'b0, 1'b0, 8'h00, 8'h00);
    end
    bus.req = 4'b0000;
    ena     = 1'b1;

    // 3-beat read from req3 with changing pad data
    bus.req     = 4'b1000;
    bus.req_wr  = 4'b0000;
    bus.req_len = 8'b1000_0000;
    @(negedge clk); chk_bus("rc_turn", 4'b1000, 1'b0, 1'b0, 8'h00, 8'h00);
    bus.req = 4'b0000;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      chk_bus($sformatf("rc_b%0d", r + 1), 4'b1000, 1'b1, (r == 2), 8'h00, 8'h00);
      chk($sformatf("rc_b%0d.rvalid", r + 1), 32'(bus.rvalid), (r == 0) ? 32'd0 : 32'd1);
      if (r > 0) chk($sformatf("rc_b%0d.rdata", r + 1), 32'(bus.rdata), 32'(rd_vals[r-1]));
      bus.uio_in = rd_vals[r];
    end
    @(negedge clk);
    chk_bus("rc_idle", 4'b0000, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("rc_idle.rvalid", 32'(bus.rvalid), 32'd1);
    chk("rc_idle.rdata",  32'(bus.rdata),  32'h33);
    @(negedge clk);
    chk("rc_after.rvalid", 32'(bus.rvalid), 32'd0);

    // Idle hygiene
    for (int h = 0; h < 10; h++) begin
      @(negedge clk);
      chk_bus($sformatf("idle%0d", h), 4'b0000, 1'b0, 1'b0, 8'h00, 8'h00);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/uio_bus_arbiter.md
# uio_bus_arbiter

Round-robin arbiter and sequencer that shares the tile's 8-bit bidirectional uio pin bus among N_REQ internal requesters inside the tt_um top. Each granted requester owns the bus for a committed burst of 1–4 beats, either driving the pins (write) or sampling them (read). The block owns uio_oe and uio_out outright and inserts a turnaround cycle on every direction change so the pads are never driven from both sides.

## Interface
- N_REQ, 4, number of requesters (supported 2–8)
- DW, 8, bus width; fixed to the uio width
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ena  in  1  tile enable; low blocks new grants
- req  in  N_REQ  per-requester request level
- req_wr  in  N_REQ  1 = write (drive pins), 0 = read (sample pins)
- req_len  in  2*N_REQ  per-requester beats-1 (0..3 → 1..4 beats)
- req_wdata  in  DW*N_REQ  per-requester write data, used on every write beat
- gnt  out  N_REQ  one-hot grant, held for the whole transaction (including turnaround)
- beat  out  1  high in each data-beat cycle
- last  out  1  high in the final data-beat cycle
- rdata  out  DW  registered capture of uio_in from the last read beat
- rvalid  out  1  one-cycle pulse, rdata updated
- uio_in  in  DW  pad input path
- uio_out  out  DW  pad output path
- uio_oe  out  DW  pad enable, 0xFF during write beats, else 0x00

## Operation
- States: IDLE, TURN, XFER.
- IDLE: gnt=0, uio_oe=0x00, beat=0. If ena && |req, pick a winner round-robin: search starts at ptr, then ptr+1, … mod N_REQ. On the edge, register gnt, latch wr_q=req_wr[w] and cnt=req_len[w], and set ptr=w+1 mod N_REQ. Go to TURN if req_wr[w] != dir_q, else XFER.
- TURN: exactly one cycle. gnt held, uio_oe=0x00, beat=0. Set dir_q=wr_q, then go to XFER.
- XFER: one beat per cycle, beat=1.
  - Write beat: uio_oe=0xFF and uio_out=req_wdata slice of the granted requester (combinational mux from registered gnt).
  - Read beat: uio_oe=0x00, and uio_in is captured into rdata at the closing edge.
  - last=1 when cnt==0. Otherwise cnt decrements each beat.
  - After the last beat, go to IDLE, clear gnt, and update dir_q=wr_q.
- uio_out = 0x00 whenever it is not a write beat.
- Committed bursts:
  - req, req_wr and req_len of the owner are ignored after grant.
  - Dropping req mid-burst does not shorten the burst.
  - ena low mid-burst lets the burst complete; it only blocks new grants in IDLE.
- Every transaction returns through IDLE, so there is a minimum of 1 idle cycle between bursts. This cycle is also the arbitration cycle.
- Reset (asynchronous, at any point, including mid-burst):
  - state=IDLE, gnt=0, beat=0, last=0, rvalid=0, rdata=0x00, uio_out=0x00, uio_oe=0x00.
  - ptr=0, dir_q=0 (read), cnt=0.
  - Reset release is synchronous to clk.

## Timing
- req sampled in IDLE at edge k:
  - gnt high from k.
  - Without turnaround, the first beat is cycle k→k+1.
  - With turnaround, the first beat is k+1→k+2.
- Burst of L beats, no turn: gnt high L cycles. With turn: L+1 cycles.
- Read: rvalid pulses in the cycle after each read beat, with rdata valid in that same cycle. A read of L beats gives L rvalid pulses, the final one one cycle after last.
- Write: uio_out/uio_oe change only combinationally on registered state/gnt and the owner's req_wdata. There is no extra latency.
- Back-to-back same-direction requests: beat period for a new owner = previous last cycle + 1 IDLE cycle.
- Direction change between bursts: last cycle + IDLE + TURN before the next beat. uio_oe is 0x00 for at least 2 cycles between opposite-direction beats.

## Test plan
- Reset mid-write-burst: assert rst during beat 2 of a 4-beat write → uio_oe=0x00, gnt=0 immediately (asynchronous). After release, req[0]&req[1] → req0 wins first.
- Round-robin fairness: req=4'b1111, all reads, len=0 → grant order 0,1,2,3,0, one beat each, 2 cycles per grant, no TURN.
- Direction turnaround:
  - Stimulus: req0 write len=1, wdata=0xA5, then req1 read len=0 with uio_in=0x3C.
  - Required: first grant goes through TURN (dir_q reset=read); uio_out=0xA5, uio_oe=0xFF for 2 beats.
  - Required: IDLE, TURN, one read beat, then rvalid with rdata=0x3C.
- Committed burst: req2 write len=3, deassert req2 after beat 1 and drop ena → all 4 beats occur, last on beat 4, no new grant while ena=0.
- Read capture: req3 read len=2, uio_in = 0x11, 0x22, 0x33 on successive beats → rvalid pulses 3×, rdata = 0x11, 0x22, 0x33, uio_oe stays 0x00 throughout.
- Idle hygiene: ena=1, req=0 for 10 cycles → gnt=0, beat=0, uio_oe=0x00, uio_out=0x00 every cycle.
